// File: rtl/pixel_mem_pkg.sv
// ============================================================================
// Module   : pixel_mem_pkg
// Brief    : Shared types and geometry of the dual-port 512x16 pixel memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pixel_mem_pkg;

  localparam int PIXEL_ADDR_W    = 9;
  localparam int PIXEL_DATA_W    = 16;
  localparam int PIXEL_MEM_DEPTH = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } frame_state_t;

endpackage

`default_nettype wire

// File: rtl/pixel_frame_streamer_if.sv
// ============================================================================
// Module   : pixel_frame_streamer_if
// Brief    : Control, pixel stream and memory-port bundle of the frame streamer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixel_frame_streamer_if
  import pixel_mem_pkg::*;
#(
  parameter int ADDR_W = PIXEL_ADDR_W,
  parameter int DATA_W = PIXEL_DATA_W
);

  logic              start;
  logic              busy;
  logic              done;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  logic [ADDR_W-1:0] address_a;
  logic [DATA_W-1:0] data_a;
  logic              wren_a;
  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] data_b;
  logic              wren_b;
  logic [DATA_W-1:0] q_b;
  logic              select;

  modport master (
    input  start, in_valid, in_data, out_ready, q_b,
    output busy, done, in_ready, out_valid, out_data,
    output address_a, data_a, wren_a, address_b, data_b, wren_b, select
  );

  modport slave (
    output start, in_valid, in_data, out_ready, q_b,
    input  busy, done, in_ready, out_valid, out_data,
    input  address_a, data_a, wren_a, address_b, data_b, wren_b, select
  );

endinterface

`default_nettype wire

// File: rtl/pixel_skid_buf.sv
// ============================================================================
// Module   : pixel_skid_buf
// Brief    : Two-entry output FIFO for read data, exposing its occupancy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_skid_buf
  import pixel_mem_pkg::*;
#(
  parameter int DATA_W = PIXEL_DATA_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;
  logic [1:0]        count_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_q <= push_data_i;
          end else begin
            tail_q <= push_data_i;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          // Head only advances when a second word is waiting, so an empty
          // buffer keeps presenting the last word it delivered.
          if (count_q == 2'd2) begin
            head_q <= tail_q;
          end
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= push_data_i;
          end else begin
            head_q <= push_data_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = head_q;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pixel_frame_streamer.sv
// ============================================================================
// Module   : pixel_frame_streamer
// Brief    : Fills one frame into the pixel memory (port A), then drains it
//            back out (port B). PIXEL_FRAME_CNT_EN adds output frame_count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_frame_streamer
  import pixel_mem_pkg::*;
#(
  parameter int FRAME_WORDS = PIXEL_MEM_DEPTH,
  parameter int ADDR_W      = PIXEL_ADDR_W,
  parameter int DATA_W      = PIXEL_DATA_W
) (
  input  logic                   clk,
  input  logic                   n_rst,
  pixel_frame_streamer_if.master bus
`ifdef PIXEL_FRAME_CNT_EN
  ,
  output logic [7:0]             frame_count
`endif
);

  // One spare bit so the read counter can reach FRAME_WORDS without wrapping.
  localparam int               CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0] WORDS     = CNT_W'(FRAME_WORDS);

  frame_state_t      state_q;
  logic [CNT_W-1:0]  wcnt_q;
  logic [CNT_W-1:0]  rcnt_q;
  logic [CNT_W-1:0]  ocnt_q;
  logic [ADDR_W-1:0] address_a_q;
  logic [ADDR_W-1:0] address_b_q;
  logic [DATA_W-1:0] data_a_q;
  logic              wren_a_q;
  logic              in_ready_q;
  logic              select_q;
  logic              busy_q;
  logic              done_q;
  logic              inflight_q;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;
  logic [1:0]        w_buf_count;
  logic [2:0]        w_occ;
  logic              w_room;
  logic              w_rd_issue;
  logic              w_last_out;

  assign w_in_fire  = in_ready_q & bus.in_valid;
  assign w_out_fire = w_out_valid & bus.out_ready;
  assign w_last_out = (state_q == DRAIN) && w_out_fire && (ocnt_q == LAST_WORD);

  // A word popped this cycle frees its slot in time for a read issued now,
  // which is what sustains one word per cycle without overflowing.
  assign w_occ      = {1'b0, w_buf_count} + {2'b00, inflight_q};
  assign w_room     = (w_occ - {2'b00, w_out_fire}) < 3'd2;
  assign w_rd_issue = (state_q == DRAIN) && (rcnt_q < WORDS) && w_room;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      ocnt_q      <= '0;
      address_a_q <= '0;
      address_b_q <= '0;
      data_a_q    <= '0;
      wren_a_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      select_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      wren_a_q   <= 1'b0;
      done_q     <= 1'b0;
      inflight_q <= w_rd_issue;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q     <= FILL;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            ocnt_q      <= '0;
            address_b_q <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        FILL: begin
          if (w_in_fire) begin
            address_a_q <= wcnt_q[ADDR_W-1:0];
            data_a_q    <= bus.in_data;
            wren_a_q    <= 1'b1;
            wcnt_q      <= wcnt_q + CNT_W'(1);
            if (wcnt_q == LAST_WORD) begin
              state_q    <= FLUSH;
              in_ready_q <= 1'b0;
            end
          end
        end
        FLUSH: begin
          state_q  <= DRAIN;
          select_q <= 1'b1;
        end
        DRAIN: begin
          if (w_rd_issue) begin
            rcnt_q <= rcnt_q + CNT_W'(1);
            if (rcnt_q != LAST_WORD) begin
              address_b_q <= address_b_q + ADDR_W'(1);
            end
          end
          if (w_out_fire) begin
            ocnt_q <= ocnt_q + CNT_W'(1);
          end
          if (w_last_out) begin
            state_q  <= IDLE;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            select_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  pixel_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid_buf (
    .clk         (clk),
    .n_rst       (n_rst),
    .push_i      (inflight_q),
    .push_data_i (bus.q_b),
    .pop_i       (w_out_fire),
    .valid_o     (w_out_valid),
    .data_o      (w_out_data),
    .count_o     (w_buf_count)
  );

`ifdef PIXEL_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      frame_cnt_q <= 8'd0;
    end else if (w_last_out) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.address_a = address_a_q;
  assign bus.data_a    = data_a_q;
  assign bus.wren_a    = wren_a_q;
  assign bus.address_b = address_b_q;
  assign bus.data_b    = '0;
  assign bus.wren_b    = 1'b0;
  assign bus.select    = select_q;

endmodule

`default_nettype wire

// File: tb/tb_pixel_frame_streamer.sv
// ============================================================================
// Module   : tb_pixel_frame_streamer
// Brief    : Directed bench for pixel_frame_streamer with a 4-word frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_frame_streamer;

  localparam int FW = 4;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  pixel_frame_streamer_if #(.ADDR_W(9), .DATA_W(16)) bus ();

`ifdef PIXEL_FRAME_CNT_EN
  logic [7:0] frame_count;
`endif

  pixel_frame_streamer #(
    .FRAME_WORDS (FW),
    .ADDR_W      (9),
    .DATA_W      (16)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
`ifdef PIXEL_FRAME_CNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  // Pixel memory: port A write, port B registered read.
  logic [15:0] mem [512];
  always @(posedge clk) begin
    if (bus.wren_a) mem[bus.address_a] <= bus.data_a;
    bus.q_b <= mem[bus.address_b];
  end

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Observation of the memory write port, output stream and done pulses.
  int          wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [15:0] out_q[$];
  int          done_cnt = 0;
  int          done_outs, done_cyc, first_acc_cyc, first_ov_cyc, sel_rise_cyc;
  bit          acc_seen, ov_seen, sel_prev;

  always @(negedge clk) begin
    if (bus.wren_a) begin
      wr_addr_q.push_back(int'(bus.address_a));
      wr_data_q.push_back(bus.data_a);
      check("wr_select", bus.select, 0);
    end
    if (bus.in_valid && bus.in_ready && !acc_seen) begin
      acc_seen      = 1'b1;
      first_acc_cyc = cyc;
    end
    if (bus.select && !sel_prev) sel_rise_cyc = cyc;
    sel_prev = bus.select;
    if (bus.out_valid && !ov_seen) begin
      ov_seen      = 1'b1;
      first_ov_cyc = cyc;
    end
    if (bus.out_valid && bus.out_ready) begin
      out_q.push_back(bus.out_data);
      check("out_select", bus.select, 1);
    end
    if (bus.done) begin
      done_cnt++;
      done_outs = out_q.size();
      done_cyc  = cyc;
    end
  end

  logic [15:0] frame_data [FW];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    out_q.delete();
    acc_seen = 1'b0;
    ov_seen  = 1'b0;
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input bit gap);
    bit acc = 1'b0;
    int w   = 0;
    if (gap) begin
      bus.in_valid = 1'b0;
      step();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!acc && w < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      w++;
      step();
    end
    bus.in_valid = 1'b0;
    check("in_accept", acc, 1);
  endtask

  task automatic wait_done(input int base);
    int w = 0;
    while (done_cnt == base && w < 100) begin
      @(posedge clk);
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt - base, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},      bus.busy, 0);
    check({tag, "_in_ready"},  bus.in_ready, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_done"},      bus.done, 0);
    check({tag, "_wren_a"},    bus.wren_a, 0);
    check({tag, "_address_a"}, bus.address_a, 0);
    check({tag, "_data_a"},    bus.data_a, 0);
    check({tag, "_address_b"}, bus.address_b, 0);
    check({tag, "_select"},    bus.select, 0);
    check({tag, "_out_data"},  bus.out_data, 0);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_wr_n"},    wr_addr_q.size(), FW);
    check({tag, "_out_n"},   out_q.size(), FW);
    check({tag, "_done_at"}, done_outs, FW);
    for (int i = 0; i < FW; i++) begin
      if (i < wr_addr_q.size()) begin
        check($sformatf("%s_wr_addr%0d", tag, i), wr_addr_q[i], i);
        check($sformatf("%s_wr_data%0d", tag, i), wr_data_q[i], frame_data[i]);
      end
      if (i < out_q.size())
        check($sformatf("%s_out%0d", tag, i), out_q[i], frame_data[i]);
    end
  endtask

  initial begin
    logic [15:0] held;
    int base;
    int w;

    n_rst         = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    check_idle("rst");
    check("rst_data_b", bus.data_b, 0);
    check("rst_wren_b", bus.wren_b, 0);
`ifdef PIXEL_FRAME_CNT_EN
    check("rst_frame_count", frame_count, 0);
`endif
    n_rst = 1'b1;
    step();

    // in_valid while IDLE is never taken
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1234;
    step();
    step();
    check("idle_in_ready", bus.in_ready, 0);
    check("idle_no_write", wr_addr_q.size(), 0);
    bus.in_valid = 1'b0;

    // Reset mid-FILL after two words
    clear_mon();
    start_frame();
    send_word(16'h5555, 1'b0);
    send_word(16'h6666, 1'b0);
    check("mid_busy",   bus.busy, 1);
    check("mid_wren_a", bus.wren_a, 1);
    check("mid_addr_a", bus.address_a, 1);
    n_rst = 1'b0;
    #1;
    check_idle("abort");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step();

    // Basic frame, which must also restart at address 0
    frame_data = '{16'hAAAA, 16'hF0F0, 16'h0001, 16'hFFFF};
    clear_mon();
    bus.out_ready = 1'b1;
    base = done_cnt;
    start_frame();
    for (int i = 0; i < FW; i++) send_word(frame_data[i], 1'b0);
    wait_done(base);
    check_frame("basic");
    check("frame_time", done_cyc - first_acc_cyc, 2 * FW + 3);
    check("drain_lat",  first_ov_cyc - sel_rise_cyc, 2);
    check("basic_busy", bus.busy, 0);

    // Output backpressure for 5 cycles after the first word
    frame_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    clear_mon();
    base = done_cnt;
    start_frame();
    for (int i = 0; i < FW; i++) send_word(frame_data[i], 1'b0);
    w = 0;
    while (out_q.size() < 1 && w < 50) begin
      @(posedge clk);
      w++;
    end
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    held = bus.out_data;
    check("bp_held", held, frame_data[1]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_stable", bus.out_data, held);
      check("bp_valid",  bus.out_valid, 1);
    end
    step();
    bus.out_ready = 1'b1;
    wait_done(base);
    check_frame("bp");

    // Input gaps, plus a start pulse during DRAIN
    frame_data = '{16'h0A0A, 16'hB0B0, 16'h0C0C, 16'hD0D0};
    clear_mon();
    base = done_cnt;
    start_frame();
    for (int i = 0; i < FW; i++) send_word(frame_data[i], 1'b1);
    w = 0;
    while (!bus.select && w < 20) begin
      step();
      w++;
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("ign_in_ready", bus.in_ready, 0);
    wait_done(base);
    check_frame("gap");
    step();
    check("ign_busy_after", bus.busy, 0);
    check("ign_in_ready_after", bus.in_ready, 0);
    check("total_done", done_cnt, 3);
`ifdef PIXEL_FRAME_CNT_EN
    check("frame_count", frame_count, 3);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
